// File: rtl/dcache_pkg.sv
// Shared dcache definitions: line/beat geometry and the refill FSM state type.
// No ports; imported by the refill engine and its line assembler.
package dcache_pkg;

  localparam int unsigned DC_LINE_BITS      = 256;
  localparam int unsigned DC_BEAT_BITS      = 64;
  localparam int unsigned DC_ADDR_BITS      = 64;
  localparam int unsigned DC_LINE_ADDR_BITS = 59;
  localparam int unsigned DC_NBEATS         = DC_LINE_BITS / DC_BEAT_BITS;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_FETCH,
    RF_DONE
  } refill_state_t;

endpackage

// File: rtl/dcache_line_asm.sv
// Beat-to-line assembler for the dcache refill engine.
// Collects memory beats in arrival order into a line buffer.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           drop any partial line and restart at beat 0
//   beat_valid      beat_data is accepted this cycle
//   beat_data       one memory beat
//   recv_cnt        number of beats received for the current line
//   line            assembled line; beat k at [k*BEAT_BITS +: BEAT_BITS]
//   done            the beat accepted this cycle completes the line
module dcache_line_asm
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_BITS = DC_LINE_BITS,
  parameter int unsigned BEAT_BITS = DC_BEAT_BITS,
  localparam int unsigned NBEATS   = LINE_BITS / BEAT_BITS,
  localparam int unsigned CNT_BITS = $clog2(NBEATS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 beat_valid,
  input  logic [BEAT_BITS-1:0] beat_data,
  output logic [CNT_BITS-1:0]  recv_cnt,
  output logic [LINE_BITS-1:0] line,
  output logic                 done
);

  localparam logic [CNT_BITS-1:0] LastBeat = CNT_BITS'(NBEATS - 1);

  logic [CNT_BITS-1:0]  recv_cnt_q, recv_cnt_d;
  logic [LINE_BITS-1:0] line_q, line_d;

  always_comb begin
    recv_cnt_d = recv_cnt_q;
    line_d     = line_q;
    if (clear) begin
      recv_cnt_d = '0;
      line_d     = '0;
    end else if (beat_valid) begin
      for (int unsigned k = 0; k < NBEATS; k++) begin
        if (recv_cnt_q == CNT_BITS'(k)) begin
          line_d[k*BEAT_BITS +: BEAT_BITS] = beat_data;
        end
      end
      recv_cnt_d = recv_cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      recv_cnt_q <= '0;
      line_q     <= '0;
    end else begin
      recv_cnt_q <= recv_cnt_d;
      line_q     <= line_d;
    end
  end

  assign recv_cnt = recv_cnt_q;
  assign line     = line_q;
  assign done     = beat_valid && !clear && (recv_cnt_q == LastBeat);

endmodule

// File: rtl/dcache_refill.sv
// Dcache miss handler: accepts one line miss, reads the line from memory as beats, then
// hands the assembled line back to the dcache for install. One miss outstanding.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   miss_req_valid/addr/retry         miss request from dcache (line address)
//   mem_req_valid/addr/retry          beat read request to memory (byte address)
//   mem_ack_valid/data/retry          beat data returned by memory, in request order
//   refill_valid/addr/data/retry      assembled line back to dcache
module dcache_refill
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_BITS = DC_LINE_BITS,
  parameter int unsigned BEAT_BITS = DC_BEAT_BITS,
  parameter int unsigned ADDR_BITS = DC_ADDR_BITS,
  localparam int unsigned NBEATS    = LINE_BITS / BEAT_BITS,
  localparam int unsigned IDX_BITS  = $clog2(NBEATS),
  localparam int unsigned CNT_BITS  = IDX_BITS + 1,
  localparam int unsigned OFF_BITS  = $clog2(BEAT_BITS / 8),
  localparam int unsigned LADR_BITS = ADDR_BITS - IDX_BITS - OFF_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss_req_valid,
  input  logic [LADR_BITS-1:0] miss_req_addr,
  output logic                 miss_req_retry,
  output logic                 mem_req_valid,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  input  logic                 mem_req_retry,
  input  logic                 mem_ack_valid,
  input  logic [BEAT_BITS-1:0] mem_ack_data,
  output logic                 mem_ack_retry,
  output logic                 refill_valid,
  output logic [LADR_BITS-1:0] refill_addr,
  output logic [LINE_BITS-1:0] refill_data,
  input  logic                 refill_retry
);

  localparam logic [CNT_BITS-1:0] NBeatsCnt = CNT_BITS'(NBEATS);

  refill_state_t        state_q, state_d;
  logic [LADR_BITS-1:0] line_addr_q, line_addr_d;
  logic [CNT_BITS-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_BITS-1:0]  recv_cnt;
  logic [LINE_BITS-1:0] line;
  logic                 miss_fire, req_fire, ack_fire, refill_fire;
  logic                 beat_valid, asm_done;

  // Outputs decode registered state only; reset forces the idle/refusing values.
  always_comb begin
    miss_req_retry = reset || (state_q != RF_IDLE);
    mem_req_valid  = !reset && (state_q == RF_FETCH) && (issue_cnt_q < NBeatsCnt);
    mem_ack_retry  = reset || (state_q != RF_FETCH);
    refill_valid   = !reset && (state_q == RF_DONE);
  end

  assign mem_req_addr = {line_addr_q, issue_cnt_q[IDX_BITS-1:0], {OFF_BITS{1'b0}}};
  assign refill_addr  = line_addr_q;
  assign refill_data  = line;

  assign miss_fire   = miss_req_valid && !miss_req_retry;
  assign req_fire    = mem_req_valid && !mem_req_retry;
  assign ack_fire    = mem_ack_valid && !mem_ack_retry;
  assign refill_fire = refill_valid && !refill_retry;

  // An ack with nothing outstanding is a protocol error; drop it rather than corrupt the line.
  assign beat_valid = ack_fire && (recv_cnt != issue_cnt_q);

  dcache_line_asm #(
    .LINE_BITS(LINE_BITS),
    .BEAT_BITS(BEAT_BITS)
  ) u_line_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (miss_fire),
    .beat_valid(beat_valid),
    .beat_data (mem_ack_data),
    .recv_cnt  (recv_cnt),
    .line      (line),
    .done      (asm_done)
  );

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    issue_cnt_d = issue_cnt_q;
    unique case (state_q)
      RF_IDLE: begin
        if (miss_fire) begin
          line_addr_d = miss_req_addr;
          issue_cnt_d = '0;
          state_d     = RF_FETCH;
        end
      end
      RF_FETCH: begin
        if (req_fire) issue_cnt_d = issue_cnt_q + CNT_BITS'(1);
        // All beats are issued before the last ack can return, so no issue is lost here.
        if (asm_done) state_d = RF_DONE;
      end
      RF_DONE: begin
        if (refill_fire) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RF_IDLE;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  ack_without_req: assert property (@(posedge clk) disable iff (reset)
                                    !(ack_fire && (recv_cnt == issue_cnt_q)));

endmodule

// File: tb/tb_dcache_refill.sv
module tb_dcache_refill;

  typedef struct {
    logic [63:0] data;
    int          ready;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          miss_req_valid;
  logic [58:0]   miss_req_addr;
  logic          miss_req_retry;
  logic          mem_req_valid;
  logic [63:0]   mem_req_addr;
  logic          mem_req_retry;
  logic          mem_ack_valid;
  logic [63:0]   mem_ack_data;
  logic          mem_ack_retry;
  logic          refill_valid;
  logic [58:0]   refill_addr;
  logic [255:0]  refill_data;
  logic          refill_retry;

  int n_checks = 0;
  int n_fail   = 0;
  int win      = 0;

  // Memory model controls and state.
  int           mem_lat    = 1;
  logic         dir_data   = 1'b0;
  logic         rnd_stall  = 1'b0;
  logic         mem_inject = 1'b0;
  logic [1:0]   stall_beat = 2'd0;
  int           stall_cnt  = 0;
  int           acks_done  = 0;
  beat_t        pend[$];
  logic [63:0]  mem_data [logic [63:0]];

  // Current miss as seen by the reference model.
  logic [58:0]  cur_line = '0;
  int           req_k    = 0;
  int           acc_win  = 0;
  int           refill_win = 0;
  logic [255:0] last_data;
  logic [58:0]  last_addr;

  always #5 clk = ~clk;
  always @(posedge clk) win <= win + 1;

  dcache_refill dut (
    .clk           (clk),
    .reset         (reset),
    .miss_req_valid(miss_req_valid),
    .miss_req_addr (miss_req_addr),
    .miss_req_retry(miss_req_retry),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_retry (mem_req_retry),
    .mem_ack_valid (mem_ack_valid),
    .mem_ack_data  (mem_ack_data),
    .mem_ack_retry (mem_ack_retry),
    .refill_valid  (refill_valid),
    .refill_addr   (refill_addr),
    .refill_data   (refill_data),
    .refill_retry  (refill_retry)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_addr(input logic [58:0] a, input int k);
    logic [1:0] kk;
    kk = k[1:0];
    return {a, kk, 3'b000};
  endfunction

  // Memory: drives at the falling edge, answers each beat in order after mem_lat cycles.
  initial begin
    logic [63:0] d;
    beat_t       b;
    mem_req_retry = 1'b0;
    mem_ack_valid = 1'b0;
    mem_ack_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend.delete();
        mem_ack_valid = 1'b0;
        mem_req_retry = 1'b0;
      end else begin
        mem_req_retry = 1'b0;
        if (mem_req_valid) begin
          if (stall_cnt > 0 && mem_req_addr[4:3] == stall_beat) begin
            mem_req_retry = 1'b1;
            stall_cnt--;
            check_eq("stall_addr_hold", 256'(mem_req_addr), 256'(beat_addr(cur_line, req_k)));
          end else if (rnd_stall) begin
            mem_req_retry = ($urandom_range(0, 3) == 0);
          end
        end
        if (mem_inject) begin
          mem_ack_valid = 1'b1;
          mem_ack_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].ready <= win) begin
          mem_ack_valid = 1'b1;
          mem_ack_data  = pend[0].data;
        end else begin
          mem_ack_valid = 1'b0;
          mem_ack_data  = {$urandom, $urandom};
        end
        #1;
        if (mem_ack_valid && !mem_ack_retry && !mem_inject && pend.size() > 0) begin
          void'(pend.pop_front());
          acks_done++;
        end
        if (mem_req_valid && !mem_req_retry) begin
          check_eq("req_addr", 256'(mem_req_addr), 256'(beat_addr(cur_line, req_k)));
          d = dir_data ? (64'hA0 + 64'(req_k)) : {$urandom, $urandom};
          mem_data[mem_req_addr] = d;
          b.data  = d;
          b.ready = win + mem_lat;
          pend.push_back(b);
          req_k++;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the refill transfer.
  task automatic run_miss(input logic [58:0] a, input int lat, input int rr_hold,
                          input int exp_lat);
    int           n;
    int           ack_bad;
    logic [255:0] exp_line;
    mem_lat = lat;
    n = 0;
    while (miss_req_retry && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("miss_accept_ready", 256'(miss_req_retry), 256'(0));
    cur_line       = a;
    req_k          = 0;
    miss_req_valid = 1'b1;
    miss_req_addr  = a;
    acc_win        = win;
    @(posedge clk);
    #1;
    miss_req_valid = 1'b0;
    miss_req_addr  = 59'($urandom);
    ack_bad = 0;
    n = 0;
    @(negedge clk);
    while (!refill_valid && n < 400) begin
      if (mem_ack_retry) ack_bad++;
      @(negedge clk);
      n++;
    end
    check_eq("refill_arrives", 256'(refill_valid), 256'(1));
    if (exp_lat >= 0) check_eq("latency", 256'(win - acc_win), 256'(exp_lat));
    check_eq("ack_retry_in_fetch", 256'(ack_bad), 256'(0));
    for (int k = 0; k < 4; k++) exp_line[k*64 +: 64] = mem_data[beat_addr(a, k)];
    check_eq("refill_addr", 256'(refill_addr), 256'(a));
    check_eq("refill_data", refill_data, exp_line);
    last_data = refill_data;
    last_addr = refill_addr;
    for (int i = 0; i < rr_hold; i++) begin
      refill_retry = 1'b1;
      @(negedge clk);
      check_eq("refill_hold_valid", 256'(refill_valid), 256'(1));
      check_eq("refill_hold_data", refill_data, exp_line);
      check_eq("refill_hold_busy", 256'(miss_req_retry), 256'(1));
    end
    refill_retry = 1'b0;
    refill_win   = win;
    @(negedge clk);
    check_eq("refill_dropped", 256'(refill_valid), 256'(0));
    check_eq("idle_after_refill", 256'(miss_req_retry), 256'(0));
  endtask

  initial begin
    int          rw;
    int          n;
    int          a0;
    int          lat;
    logic [58:0] ra;
    reset          = 1'b1;
    miss_req_valid = 1'b0;
    miss_req_addr  = '0;
    refill_retry   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_miss_retry", 256'(miss_req_retry), 256'(1));
    check_eq("rst_mem_req_valid", 256'(mem_req_valid), 256'(0));
    check_eq("rst_refill_valid", 256'(refill_valid), 256'(0));
    check_eq("rst_ack_retry", 256'(mem_ack_retry), 256'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_miss_retry", 256'(miss_req_retry), 256'(0));
    check_eq("idle_ack_retry", 256'(mem_ack_retry), 256'(1));
    check_eq("idle_buffer", refill_data, 256'(0));
    check_eq("idle_mem_req_valid", 256'(mem_req_valid), 256'(0));

    // Basic line with known beats.
    dir_data = 1'b1;
    run_miss(59'h1, 1, 0, 6);
    dir_data = 1'b0;
    check_eq("t1_data", last_data, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    check_eq("t1_addr", 256'(last_addr), 256'(1));

    // Request stall on beat 2.
    stall_beat = 2'd2;
    stall_cnt  = 3;
    run_miss(59'h123_4567, 1, 0, 9);
    check_eq("t2_stall_used", 256'(stall_cnt), 256'(0));

    // Install stalled for 5 cycles.
    run_miss(59'h0AB_CDEF, 1, 5, 6);

    // Back-to-back misses.
    run_miss(59'h10, 1, 0, 6);
    rw = refill_win;
    run_miss(59'h7FF, 1, 0, 6);
    check_eq("t4_b2b_accept", 256'(acc_win), 256'(rw + 1));

    // Reset mid-fetch after beat 1 is acked.
    n = 0;
    while (miss_req_retry && n < 100) begin
      @(negedge clk);
      n++;
    end
    mem_lat        = 1;
    cur_line       = 59'h9;
    req_k          = 0;
    miss_req_valid = 1'b1;
    miss_req_addr  = 59'h9;
    @(posedge clk);
    #1;
    miss_req_valid = 1'b0;
    a0 = acks_done;
    n  = 0;
    @(negedge clk);
    while (acks_done < a0 + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_beat1_acked", 256'(acks_done >= a0 + 2), 256'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_req_valid", 256'(mem_req_valid), 256'(0));
    check_eq("t5_rst_refill_valid", 256'(refill_valid), 256'(0));
    check_eq("t5_rst_miss_retry", 256'(miss_req_retry), 256'(1));
    @(posedge clk);
    #1;
    reset      = 1'b0;
    mem_inject = 1'b1;
    @(negedge clk);
    check_eq("t5_idle", 256'(miss_req_retry), 256'(0));
    check_eq("t5_req_valid", 256'(mem_req_valid), 256'(0));
    check_eq("t5_late_ack_refused", 256'(mem_ack_retry), 256'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("t5_late_ack_refused2", 256'(mem_ack_retry), 256'(1));
    @(posedge clk);
    #1;
    mem_inject = 1'b0;
    @(negedge clk);
    run_miss(59'h5, 1, 2, 6);

    // Slow memory, acks interleaved with issue.
    run_miss(59'h2_0000_1234, 4, 0, 9);

    // Randomised misses: address, latency, request stalls, install stalls.
    for (int i = 0; i < 20; i++) begin
      ra        = 59'({$urandom, $urandom});
      lat       = int'($urandom_range(1, 5));
      rnd_stall = ($urandom_range(0, 1) == 1);
      run_miss(ra, lat, int'($urandom_range(0, 4)), rnd_stall ? -1 : 5 + lat);
    end
    rnd_stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
